// File: rtl/fetch_sequencer_pkg.sv
// Shared constants and types for the fetch stage and instruction memory.
// INT_* codes are the injection encodings seen by instruction_memory on INT_counter.
package fetch_sequencer_pkg;

  localparam logic [2:0] INT_IDLE    = 3'd0;
  localparam logic [2:0] INT_PC_HIGH = 3'd1;
  localparam logic [2:0] INT_PC_LOW  = 3'd2;
  localparam logic [2:0] INT_FLAGS   = 3'd3;
  localparam logic [2:0] INT_WAIT    = 3'd4;

  // Strobes from the interrupt sequencer to the PC register logic.
  typedef struct packed {
    logic hold_pc;        // states 3 and 2: PC frozen
    logic load_vector;    // state 1: PC takes the ISR vector
    logic capture_saved;  // entering state 3: latch the resume address
    logic in_service;     // states 3/2/1: late redirects retarget saved_pc
  } pc_ctrl_t;

endpackage

// File: rtl/fetch_sequencer_int_sequencer.sv
// Interrupt injection sequencer: owns int_pending, INT_counter and int_ack,
// and tells the PC register what to do each cycle.
module fetch_sequencer_int_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       int_req,
  input  logic       two_word,
  output logic [2:0] int_counter,
  output logic       int_ack,
  output pc_ctrl_t   pc_ctrl
);

  logic [2:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       ack_q, ack_d;
  logic       int_hit;

  assign int_hit = pend_q | int_req;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    pc_ctrl = '0;

    if (stall) begin
      // A request arriving during a freeze is remembered, not lost.
      if (cnt_q == INT_IDLE && int_req) pend_d = 1'b1;
    end else begin
      case (cnt_q)
        INT_IDLE: begin
          if (int_hit) begin
            if (two_word) begin
              // Let the operand word be fetched before injecting.
              cnt_d  = INT_WAIT;
              pend_d = 1'b1;
            end else begin
              cnt_d                 = INT_FLAGS;
              pend_d                = 1'b0;
              pc_ctrl.capture_saved = 1'b1;
            end
          end
        end
        INT_WAIT: begin
          cnt_d                 = INT_FLAGS;
          pend_d                = 1'b0;
          pc_ctrl.capture_saved = 1'b1;
        end
        INT_FLAGS: begin
          cnt_d              = INT_PC_LOW;
          pc_ctrl.hold_pc    = 1'b1;
          pc_ctrl.in_service = 1'b1;
        end
        INT_PC_LOW: begin
          cnt_d              = INT_PC_HIGH;
          pc_ctrl.hold_pc    = 1'b1;
          pc_ctrl.in_service = 1'b1;
        end
        INT_PC_HIGH: begin
          cnt_d               = INT_IDLE;
          ack_d               = 1'b1;
          pc_ctrl.load_vector = 1'b1;
          pc_ctrl.in_service  = 1'b1;
        end
        default: cnt_d = INT_IDLE;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments; reset is synchronous so it sits inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= INT_IDLE;
      pend_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      ack_q  <= ack_d;
    end
  end

  assign int_counter = cnt_q;
  assign int_ack     = ack_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC register with interrupt injection; drives pc and INT_counter
// of instruction_memory and publishes the resume address for push-PC words.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                    pc_width   = 32,
  parameter logic [pc_width-1:0]   RESET_PC   = '0,
  parameter logic [pc_width-1:0]   INT_VECTOR = pc_width'(1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                int_req,
  input  logic                two_word,
  input  logic                redirect_en,
  input  logic [pc_width-1:0] redirect_pc,
  output logic [pc_width-1:0] pc,
  output logic [2:0]          INT_counter,
  output logic [pc_width-1:0] saved_pc,
  output logic                int_ack
);

  logic [pc_width-1:0] pc_q, pc_d;
  logic [pc_width-1:0] saved_pc_q, saved_pc_d;
  logic [pc_width-1:0] next_pc;
  pc_ctrl_t            pc_ctrl;

  fetch_sequencer_int_sequencer u_int_sequencer (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .int_req     (int_req),
    .two_word    (two_word),
    .int_counter (INT_counter),
    .int_ack     (int_ack),
    .pc_ctrl     (pc_ctrl)
  );

  // Increment wraps naturally at pc_width bits.
  assign next_pc = redirect_en ? redirect_pc : pc_q + pc_width'(1);

  always_comb begin
    pc_d       = pc_q;
    saved_pc_d = saved_pc_q;
    if (!stall) begin
      if (pc_ctrl.load_vector)   pc_d = INT_VECTOR;
      else if (!pc_ctrl.hold_pc) pc_d = next_pc;

      // A branch resolving during injection corrects where the ISR will return.
      if (pc_ctrl.capture_saved)                  saved_pc_d = next_pc;
      else if (pc_ctrl.in_service && redirect_en) saved_pc_d = redirect_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      saved_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      saved_pc_q <= saved_pc_d;
    end
  end

  assign pc       = pc_q;
  assign saved_pc = saved_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a cycle model predicts every output,
// expectations are queued when stimulus is driven and compared after the edge.
module tb_fetch_sequencer;

  localparam int          W   = 32;
  localparam logic [31:0] VEC = 32'd1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall = 1'b0;
  logic          int_req = 1'b0;
  logic          two_word = 1'b0;
  logic          redirect_en = 1'b0;
  logic [W-1:0]  redirect_pc = '0;
  logic [W-1:0]  pc;
  logic [2:0]    INT_counter;
  logic [W-1:0]  saved_pc;
  logic          int_ack;

  fetch_sequencer #(.pc_width(W), .RESET_PC('0), .INT_VECTOR(VEC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .int_req     (int_req),
    .two_word    (two_word),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .INT_counter (INT_counter),
    .saved_pc    (saved_pc),
    .int_ack     (int_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic [31:0] saved;
    logic        ack;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc, m_saved;
  logic [2:0]  m_cnt;
  logic        m_ack, m_pend;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic s, input logic ir, input logic tw,
                       input logic re, input logic [31:0] rp);
    logic [31:0] np;
    if (r) begin
      m_pc = '0; m_saved = '0; m_cnt = 3'd0; m_ack = 1'b0; m_pend = 1'b0;
    end else if (s) begin
      m_ack = 1'b0;
      if (m_cnt == 3'd0 && ir) m_pend = 1'b1;
    end else begin
      np    = re ? rp : m_pc + 32'd1;
      m_ack = 1'b0;
      case (m_cnt)
        3'd0: begin
          m_pc = np;
          if (m_pend || ir) begin
            if (tw) begin m_cnt = 3'd4; m_pend = 1'b1; end
            else begin m_cnt = 3'd3; m_saved = np; m_pend = 1'b0; end
          end
        end
        3'd4: begin m_pc = np; m_saved = np; m_cnt = 3'd3; m_pend = 1'b0; end
        3'd3, 3'd2: begin
          if (re) m_saved = rp;
          m_cnt = m_cnt - 3'd1;
        end
        3'd1: begin
          if (re) m_saved = rp;
          m_pc = VEC; m_cnt = 3'd0; m_ack = 1'b1;
        end
        default: m_cnt = 3'd0;
      endcase
    end
  endtask

  // Drive one cycle of stimulus, queue the prediction, then compare after the edge.
  task automatic step(input logic r, input logic s, input logic ir, input logic tw,
                      input logic re, input logic [31:0] rp);
    exp_t e, got;
    rst = r; stall = s; int_req = ir; two_word = tw; redirect_en = re; redirect_pc = rp;
    model(r, s, ir, tw, re, rp);
    e.pc = m_pc; e.cnt = m_cnt; e.saved = m_saved; e.ack = m_ack;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("pc",       pc,                  got.pc);
    check("int_cnt",  {29'd0, INT_counter}, {29'd0, got.cnt});
    check("saved_pc", saved_pc,            got.saved);
    check("int_ack",  {31'd0, int_ack},    {31'd0, got.ack});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // Reset and free-running fetch
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("rst_pc", pc, 32'd0);
    check("rst_cnt", {29'd0, INT_counter}, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      check("free_pc", pc, i);
    end
    idle(1);
    check("pc_before_int", pc, 32'd5);

    // Single-word interrupt at pc=5
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("int_cnt3", {29'd0, INT_counter}, 32'd3);
    check("int_saved", saved_pc, 32'd6);
    check("int_pc_hold", pc, 32'd6);
    idle(2);
    check("int_cnt1", {29'd0, INT_counter}, 32'd1);
    idle(1);
    check("vec_pc", pc, VEC);
    check("vec_ack", {31'd0, int_ack}, 32'd1);
    idle(1);
    check("ack_pulse", {31'd0, int_ack}, 32'd0);

    // Two-word interrupt at pc=8, with a late redirect in state 2
    idle(6);
    check("pc_eight", pc, 32'd8);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    check("wait_cnt", {29'd0, INT_counter}, 32'd4);
    check("wait_pc", pc, 32'd9);
    idle(1);
    check("wait_saved", saved_pc, 32'd10);
    idle(1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40);   // int_req here must be ignored
    check("redir_saved", saved_pc, 32'h40);
    check("redir_pc", pc, 32'd10);
    idle(3);
    check("no_nest", {29'd0, INT_counter}, 32'd0);

    // Stall for two cycles in state 3
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("stall_cnt", {29'd0, INT_counter}, 32'd3);
    idle(3);
    check("stall_vec", pc, VEC);

    // Request latched during an idle stall, serviced afterwards
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    idle(1);
    check("latched_req", {29'd0, INT_counter}, 32'd3);
    idle(4);

    // Redirect and interrupt together in idle
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h123);
    check("redir_int_saved", saved_pc, 32'h123);
    idle(4);

    // Wrap at all-ones
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    idle(1);
    check("wrap_pc", pc, 32'd0);

    // Reset in state 2, then reset while a request is pending in WAIT
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("rst_mid_pc", pc, 32'd0);
    check("rst_mid_ack", {31'd0, int_ack}, 32'd0);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle(4);
    check("pend_dropped", {29'd0, INT_counter}, 32'd0);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(7) == 0), ($urandom_range(15) == 0),
           ($urandom_range(3) == 0), ($urandom_range(7) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Fetch-stage PC and interrupt-injection controller, directly upstream of instruction_memory; drives its `pc` and `INT_counter` inputs.
- In normal operation it advances or redirects the PC.
- On an interrupt it holds the PC, steps INT_counter 3→2→1 so memory injects push-flags / push-PC-low / push-PC-high, then vectors to the ISR.
- Publishes the resume PC (`saved_pc`) consumed by the push instructions.

Parameters:
- pc_width, 32, width of pc / saved_pc / redirect_pc.
- RESET_PC, 0, pc value after reset.
- INT_VECTOR, 1, pc loaded after the injection sequence.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard freeze; all state holds.
- int_req  in  1  external interrupt, level or pulse; sampled each cycle.
- two_word  in  1  instruction fetched last cycle carries an immediate (LDM/CALL-style); next fetch word is its operand.
- redirect_en  in  1  branch/jump/RTI resolved this cycle.
- redirect_pc  in  pc_width  redirect target.
- pc  out  pc_width  fetch address to instruction_memory.
- INT_counter  out  3  injection code to instruction_memory.
- saved_pc  out  pc_width  resume address for push-PC words.
- int_ack  out  1  one-cycle pulse when ISR vector is loaded.

Behaviour:
- Reset values (rst high at posedge, overrides everything):
  - pc=RESET_PC, INT_counter=0, saved_pc=0, int_ack=0, int_pending=0.
  - A reset mid-sequence aborts the sequence and drops any pending interrupt.
- stall=1: pc, INT_counter, saved_pc and int_pending hold. int_ack=0. int_req is still latched into int_pending.
- int_pending:
  - Set when int_req=1 while INT_counter==0.
  - Cleared on entry to state 3.
  - int_req while INT_counter!=0 is ignored (no nesting).
- States, encoded in INT_counter:
  - IDLE(0): pc <= redirect_en ? redirect_pc : pc+1.
    - If int_pending (or int_req this cycle) and two_word=0 → 3.
    - If int_pending (or int_req this cycle) and two_word=1 → WAIT(4).
  - WAIT(4): the operand word is fetched; pc advances/redirects as in IDLE; → 3 unconditionally.
  - On entry to 3: saved_pc <= the next-pc value computed that cycle (redirect_pc if redirect_en, else pc+1); pc <= that same value, then holds.
  - 3 (push flags) → 2 (push pc low) → 1 (push pc high), one cycle each, pc held.
  - 1 → 0: pc <= INT_VECTOR; int_ack=1 for exactly that cycle.
- Redirect during states 3/2/1: saved_pc <= redirect_pc; pc unchanged. A late branch resolution corrects the resume point.
- Simultaneous redirect_en and interrupt entry in IDLE: the redirect target becomes saved_pc.
- Arithmetic: pc+1 is modulo 2^pc_width; all-ones wraps to 0.
- Latency:
  - INT_counter is registered, so memory sees the new code on the next posedge.
  - Interrupt response is 4 cycles from int_req to vector load (5 with WAIT), plus any stall cycles.

Decomposition:
- Shared package: localparams INT_IDLE=3'd0, INT_PC_HIGH=3'd1, INT_PC_LOW=3'd2, INT_FLAGS=3'd3, INT_WAIT=3'd4. The same constants replace literals in instruction_memory.
- One natural sub-module, int_sequencer: owns int_pending, INT_counter and int_ack. Outputs a hold_pc / load_vector / capture_saved strobe set to the PC register logic in fetch_sequencer.

Test Plan:
- Reset then 4 free cycles: pc 0,1,2,3,4; INT_counter=0; int_ack=0.
- int_req pulse at pc=5, two_word=0:
  - INT_counter 3,2,1,0 on successive cycles.
  - saved_pc=6; pc holds 6 during 3/2/1, then pc=INT_VECTOR=1 with int_ack=1 for one cycle.
- int_req with two_word=1 at pc=8: INT_counter=4 with pc=9, then 3 with saved_pc=10, then 2, 1, vector.
- redirect_en=1, redirect_pc=0x40 while INT_counter=2: saved_pc becomes 0x40, pc unchanged.
- stall=1 for 2 cycles at INT_counter=3: counter and pc frozen, then sequence resumes 2,1,0.
- rst asserted at INT_counter=2: next cycle pc=RESET_PC, INT_counter=0, int_pending=0, no int_ack.
